// File: rtl/rvh_uncore_param_pkg.sv
// Uncore data-channel parameters and burst serializer types.
// Shared by the cache-line burst serializer.
package rvh_uncore_param_pkg;

   localparam int DATA_LINE_W         = 512;
   localparam int DATA_LENGTH_PER_PKG = 64;
   localparam int DATA_BURST_NUM      = 8;
   localparam int DATA_BURST_NUM_W    = 3;

   typedef logic [DATA_BURST_NUM_W-1:0]    burst_idx_t;
   typedef logic [DATA_LENGTH_PER_PKG-1:0] burst_beat_t;

   typedef enum logic [0:0] {
      SER_IDLE = 1'b0,
      SER_SEND = 1'b1
   } ser_state_e;

endpackage

// File: rtl/rvh_cache_line_burst_ser.sv
// Cache line to uncore beat serializer, back-to-back capable.
// Optional `BURST_CRITICAL_WORD_FIRST_EN: start at line_crit_i.
module rvh_cache_line_burst_ser
   import rvh_uncore_param_pkg::*;
#(
   parameter int LINE_W   = DATA_LINE_W,
   parameter int BEAT_W   = DATA_LENGTH_PER_PKG,
   parameter int BEAT_NUM = DATA_BURST_NUM,
   parameter int IDX_W    = DATA_BURST_NUM_W,
   parameter int TXN_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              line_vld_i,
   output logic              line_rdy_o,
   input  logic [LINE_W-1:0] line_data_i,
   input  logic [IDX_W-1:0]  line_crit_i,
   input  logic [TXN_W-1:0]  line_txn_i,
   output logic              beat_vld_o,
   input  logic              beat_rdy_i,
   output logic [BEAT_W-1:0] beat_data_o,
   output logic [IDX_W-1:0]  beat_idx_o,
   output logic              beat_last_o,
   output logic [TXN_W-1:0]  beat_txn_o,
   output logic              busy_o
);

   localparam int CNT_W = IDX_W + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEAT_NUM - 1);

   generate
      if ((BEAT_NUM * BEAT_W != LINE_W) ||
          ((BEAT_NUM & (BEAT_NUM - 1)) != 0) ||
          (BEAT_NUM != (1 << IDX_W))) begin : g_bad_cfg
         $error("burst_ser: bad line/beat geometry");
      end
   endgenerate

   ser_state_e        state_q;
   logic [LINE_W-1:0] line_q;
   logic [IDX_W-1:0]  idx_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [TXN_W-1:0]  txn_q;
   logic [IDX_W-1:0]  start_idx;
   logic              line_fire;
   logic              beat_fire;
   logic              sending;

`ifdef BURST_CRITICAL_WORD_FIRST_EN
   assign start_idx = line_crit_i;
`else
   logic unused_crit;
   assign unused_crit = ^line_crit_i;
   assign start_idx   = '0;
`endif

   assign sending     = (state_q == SER_SEND);
   assign beat_vld_o  = sending;
   assign busy_o      = sending;
   assign beat_last_o = sending && (cnt_q == LAST_CNT);
   assign beat_idx_o  = idx_q;
   assign beat_txn_o  = txn_q;
   assign beat_data_o = line_q[int'(idx_q) * BEAT_W +: BEAT_W];

   // Refill on the last beat's fire keeps the channel bubble-free.
   assign line_rdy_o  = !sending || (beat_last_o && beat_rdy_i);
   assign line_fire   = line_vld_i && line_rdy_o;
   assign beat_fire   = beat_vld_o && beat_rdy_i;

   always_ff @(posedge clk) begin
      if (line_fire) begin
         line_q <= line_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= SER_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         txn_q   <= '0;
      end else if (line_fire) begin
         state_q <= SER_SEND;
         idx_q   <= start_idx;
         cnt_q   <= '0;
         txn_q   <= line_txn_i;
      end else if (beat_fire) begin
         idx_q <= idx_q + 1'b1;
         if (beat_last_o) begin
            state_q <= SER_IDLE;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_rvh_cache_line_burst_ser.sv
// Directed bench for rvh_cache_line_burst_ser.
// Expected beat order follows `BURST_CRITICAL_WORD_FIRST_EN when defined.
module tb_rvh_cache_line_burst_ser;

   logic         clk = 1'b0;
   logic         rst;
   logic         line_vld;
   logic         line_rdy;
   logic [511:0] line_data;
   logic [2:0]   line_crit;
   logic [7:0]   line_txn;
   logic         beat_vld;
   logic         beat_rdy;
   logic [63:0]  beat_data;
   logic [2:0]   beat_idx;
   logic         beat_last;
   logic [7:0]   beat_txn;
   logic         busy;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rvh_cache_line_burst_ser dut (
      .clk         (clk),
      .rst         (rst),
      .line_vld_i  (line_vld),
      .line_rdy_o  (line_rdy),
      .line_data_i (line_data),
      .line_crit_i (line_crit),
      .line_txn_i  (line_txn),
      .beat_vld_o  (beat_vld),
      .beat_rdy_i  (beat_rdy),
      .beat_data_o (beat_data),
      .beat_idx_o  (beat_idx),
      .beat_last_o (beat_last),
      .beat_txn_o  (beat_txn),
      .busy_o      (busy)
   );

   task automatic check_eq(input string tag,
                           input logic [63:0] obs,
                           input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] pat(input int sel, input int k);
      case (sel)
         0:       pat = 64'(k);
         1:       pat = 64'hDEAD_0000_0000_0000 + 64'(k);
         2:       pat = {32'hCAFE_0000 + 32'(k), 32'h1234_5670 + 32'(k)};
         default: pat = ~64'(k);
      endcase
   endfunction

   function automatic logic [511:0] mk_line(input int sel);
      logic [511:0] l;
      for (int k = 0; k < 8; k++) l[k*64 +: 64] = pat(sel, k);
      return l;
   endfunction

   function automatic logic [2:0] st(input logic [2:0] crit);
`ifdef BURST_CRITICAL_WORD_FIRST_EN
      return crit;
`else
      return 3'd0 & crit;
`endif
   endfunction

   task automatic offer(input int sel, input logic [2:0] crit,
                        input logic [7:0] txn);
      line_vld  = 1'b1;
      line_data = mk_line(sel);
      line_crit = crit;
      line_txn  = txn;
   endtask

   task automatic expect_beat(input string tag, input logic [2:0] idx,
                              input int sel, input logic last,
                              input logic [7:0] txn);
      check_eq({tag, "_vld"}, 64'(beat_vld), 64'd1);
      check_eq({tag, "_idx"}, 64'(beat_idx), 64'(idx));
      check_eq({tag, "_data"}, beat_data, pat(sel, int'(idx)));
      check_eq({tag, "_last"}, 64'(beat_last), 64'(last));
      check_eq({tag, "_txn"}, 64'(beat_txn), 64'(txn));
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int fires;
      int cyc;
      rst       = 1'b0;
      line_vld  = 1'b0;
      line_data = '0;
      line_crit = '0;
      line_txn  = '0;
      beat_rdy  = 1'b0;
      #2;
      check_eq("rst_vld", 64'(beat_vld), 64'd0);
      check_eq("rst_last", 64'(beat_last), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_idx", 64'(beat_idx), 64'd0);
      check_eq("rst_txn", 64'(beat_txn), 64'd0);
      next_cyc();
      rst = 1'b1;
      #1;
      check_eq("rst_rel_line_rdy", 64'(line_rdy), 64'd1);

      // single line, crit=5, free-flowing downstream
      next_cyc();
      offer(0, 3'd5, 8'h5A);
      beat_rdy = 1'b1;
      #1;
      check_eq("t1_line_rdy", 64'(line_rdy), 64'd1);
      next_cyc();
      line_vld = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         expect_beat("t1", st(3'd5) + 3'(i), 0, i == 7, 8'h5A);
         next_cyc();
      end
      #1;
      check_eq("t1_end_vld", 64'(beat_vld), 64'd0);
      check_eq("t1_end_busy", 64'(busy), 64'd0);

      // random downstream stalls
      next_cyc();
      offer(2, 3'd6, 8'hC3);
      next_cyc();
      line_vld = 1'b0;
      fires = 0;
      cyc = 0;
      while (fires < 8 && cyc < 200) begin
         beat_rdy = 1'($urandom_range(0, 1));
         #1;
         expect_beat("t3", st(3'd6) + 3'(fires), 2, fires == 7, 8'hC3);
         check_eq("t3_line_rdy", 64'(line_rdy),
                  64'((fires == 7) && beat_rdy));
         if (beat_rdy) fires++;
         next_cyc();
         cyc++;
      end
      check_eq("t3_fires", 64'(fires), 64'd8);
      #1;
      check_eq("t3_end_vld", 64'(beat_vld), 64'd0);

      // two lines back to back
      next_cyc();
      beat_rdy = 1'b1;
      offer(0, 3'd1, 8'h11);
      next_cyc();
      offer(3, 3'd4, 8'h22);
      for (int i = 0; i < 16; i++) begin
         #1;
         if (i < 8)
            expect_beat("t4a", st(3'd1) + 3'(i), 0, i == 7, 8'h11);
         else
            expect_beat("t4b", st(3'd4) + 3'(i - 8), 3, i == 15, 8'h22);
         check_eq("t4_line_rdy", 64'(line_rdy), 64'((i == 7) || (i == 15)));
         next_cyc();
         if (i == 7) line_vld = 1'b0;
      end
      #1;
      check_eq("t4_end_vld", 64'(beat_vld), 64'd0);

      // reset in the middle of a burst
      next_cyc();
      offer(1, 3'd2, 8'h33);
      next_cyc();
      line_vld = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         expect_beat("t5_pre", st(3'd2) + 3'(i), 1, 1'b0, 8'h33);
         next_cyc();
      end
      rst = 1'b0;
      #1;
      check_eq("t5_rst_vld", 64'(beat_vld), 64'd0);
      check_eq("t5_rst_busy", 64'(busy), 64'd0);
      check_eq("t5_rst_idx", 64'(beat_idx), 64'd0);
      check_eq("t5_rst_txn", 64'(beat_txn), 64'd0);
      check_eq("t5_rst_last", 64'(beat_last), 64'd0);
      next_cyc();
      rst = 1'b1;
      #1;
      check_eq("t5_rel_line_rdy", 64'(line_rdy), 64'd1);
      check_eq("t5_rel_vld", 64'(beat_vld), 64'd0);
      offer(1, 3'd2, 8'h44);
      next_cyc();
      line_vld = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         expect_beat("t5_new", st(3'd2) + 3'(i), 1, i == 7, 8'h44);
         next_cyc();
      end

      // long idle with noise on unused inputs
      for (int i = 0; i < 20; i++) begin
         line_vld  = 1'b0;
         line_data = {16{$urandom}};
         line_txn  = 8'($urandom);
         beat_rdy  = 1'($urandom_range(0, 1));
         #1;
         check_eq("t6_vld", 64'(beat_vld), 64'd0);
         check_eq("t6_busy", 64'(busy), 64'd0);
         next_cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
